dino_obstacle_game: RTL and testbench
=====================================

Name: dino_obstacle_game

Overview:
- Consumer side of the dino jump interface: takes the dino height (dinoY) and the jump-accepted strobe (dinoJumpGood).
- Scrolls a single obstacle toward the dino, detects collisions, and keeps the score and jump count.
- Runs the game state machine that starts, ends and restarts a round.
- Sits between the jump block and the display/score renderer.

Parameters:
- TICK_DIV, 750000, clock cycles per scroll step.
- FLOOR_Y, 101, dinoY value when the dino is on the floor (larger values are higher).
- DINO_X, 20, left column of the dino hitbox.
- DINO_W, 8, hitbox width; collision columns are DINO_X..DINO_X+DINO_W-1.
- OBST_H, 12, obstacle height; collision requires dinoY < FLOOR_Y+OBST_H.
- OBST_START, 159, obstacle X after reset or respawn.
- OBST_STEP, 2, pixels moved per tick.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- button  in  1  start/restart request, level; internally edge-detected
- dinoY  in  8  dino height from the jump block
- dinoJumpGood  in  1  one-cycle jump-accepted strobe
- obstX  out  8  obstacle X position
- score  out  16  four packed BCD digits, [15:12] most significant
- jumpCount  out  8  jumps accepted this round, saturating at 255
- hit  out  1  one-cycle collision pulse
- running  out  1  high in state RUN
- gameOver  out  1  high in state OVER

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, obstX=OBST_START, score=0, jumpCount=0.
  - hit=0, running=0, gameOver=0, tick counter=0, button history register=0.
- All outputs are registered.
- Button press: btnRise = button & ~button_q, with button_q registered every cycle.
- State machine:
  - IDLE: outputs hold their reset values. On btnRise go to RUN next cycle, with the tick counter at 0.
  - RUN:
    - The tick counter counts 0..TICK_DIV-1 and wraps. tick is asserted in the cycle where count==TICK_DIV-1.
    - On tick with obstX >= OBST_STEP: obstX -= OBST_STEP.
    - On tick with obstX < OBST_STEP: obstX=OBST_START and score increments by one (BCD, saturating at 9999).
    - dinoJumpGood increments jumpCount (saturating).
    - Collision is evaluated every cycle on the registered obstX and the live dinoY: DINO_X <= obstX <= DINO_X+DINO_W-1 and dinoY < FLOOR_Y+OBST_H. On collision go to HIT; neither obstX nor score updates that cycle, even if tick is also asserted.
    - btnRise has no effect in RUN.
  - HIT: hit=1 for exactly this one cycle, then go unconditionally to OVER.
  - OVER: gameOver=1; obstX, score and jumpCount freeze. On btnRise: obstX=OBST_START, score=0, jumpCount=0, state=RUN (direct restart, no pass through IDLE).
- Same-cycle events in RUN: collision beats tick and dinoJumpGood, so no score or jump increment on the hit cycle.
- The tick counter is held at 0 in every state except RUN.
- Reset mid-round returns to IDLE in the same cycle (asynchronous); nothing is retained.
- Arithmetic: obstX uses unsigned 8-bit. The OBST_STEP check prevents underflow wrap, so obstX never exceeds OBST_START.

Optional Feature:
- Macro: DINO_SPEEDUP_EN.
- Defined: the effective step is 2*OBST_STEP once score >= 0x0050 (BCD 50). The underflow check and respawn use the effective step.
- Not defined: the step is always OBST_STEP; no comparator logic is present.

Decomposition:
- Package dino_pkg:
  - state enum with IDLE, RUN, HIT, OVER.
  - FLOOR_Y default constant, shared with the jump block.
  - BCD digit typedef (4-bit).
- One sub-module: dino_score_bcd.
  - 4-digit BCD incrementer/register with synchronous clear, increment enable and saturation at 9999.
  - Asynchronous active-high reset.

Test Plan (TICK_DIV=4, other parameters at default):
- Start: rst pulse, then button high -> running=1 one cycle after the button edge; obstX=159 then 157 after 4 cycles, 155 after 8.
- Respawn: dinoY=200 held through the dino columns; run until obstX=1 -> next tick gives obstX=159 and score=0x0001. Repeat 10 passes -> score=0x0010.
- Ground collision: dinoY=101 as obstX reaches 27 -> hit=1 for one cycle, then gameOver=1. obstX stays at 27 and score is frozen.
- Jump clearance: dinoJumpGood pulse, dinoY=121 while obstX is in 20..27, then 101 after obstX=19 -> no hit, jumpCount=1, and the round continues.
- Simultaneous events: collision in the same cycle as tick and dinoJumpGood -> obstX, score and jumpCount unchanged; hit=1 next cycle.
- Restart and reset: btnRise in OVER -> score=0, obstX=159, running=1. Asserting rst mid-RUN -> IDLE immediately with all outputs at their reset values.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino obstacle game and its jump block.
package dino_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_e;

  // dinoY when standing on the floor; the jump block uses the same value.
  localparam int FLOOR_Y_DEF = 101;
  localparam int BCD_DIGITS  = 4;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/dino_score_bcd.sv
// Packed BCD score register: synchronous clear, increment enable, and
// saturation at all-nines.
module dino_score_bcd
  import dino_pkg::*;
#(
  parameter int NUM_DIGITS = BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [NUM_DIGITS*4-1:0] score_o
);

  bcd_t [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0] nines;
  logic [NUM_DIGITS-1:0] carry;

  // An increment at full scale is dropped so the score holds at 9999.
  assign carry[0] = inc_i & ~(&nines);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign nines[g] = (dig_q[g] == 4'd9);
    assign dig_d[g] = clr_i    ? 4'd0 :
                      carry[g] ? (nines[g] ? 4'd0 : dig_q[g] + 4'd1) :
                                 dig_q[g];
    if (g < NUM_DIGITS - 1) begin : g_carry
      assign carry[g+1] = carry[g] & nines[g];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dig_q <= '0;
    else     dig_q <= dig_d;
  end

  assign score_o = dig_q;

endmodule

// File: rtl/dino_obstacle_game.sv
// Obstacle scroller, collision detector and round state machine for the dino game.
// Optional DINO_SPEEDUP_EN doubles the scroll step once the score reaches BCD 50.
module dino_obstacle_game
  import dino_pkg::*;
#(
  parameter int TICK_DIV   = 750000,
  parameter int FLOOR_Y    = FLOOR_Y_DEF,
  parameter int DINO_X     = 20,
  parameter int DINO_W     = 8,
  parameter int OBST_H     = 12,
  parameter int OBST_START = 159,
  parameter int OBST_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [7:0]  dinoY,
  input  logic        dinoJumpGood,
  output logic [7:0]  obstX,
  output logic [15:0] score,
  output logic [7:0]  jumpCount,
  output logic        hit,
  output logic        running,
  output logic        gameOver
);

  localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]      X_LO      = 8'(DINO_X);
  localparam logic [7:0]      X_HI      = 8'(DINO_X + DINO_W - 1);
  localparam logic [7:0]      Y_TOP     = 8'(FLOOR_Y + OBST_H);
  localparam logic [7:0]      START     = 8'(OBST_START);
  localparam logic [7:0]      STEP      = 8'(OBST_STEP);

  state_e        state_q, state_d;
  logic          btn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    obst_q, obst_d;
  logic [7:0]    jc_q, jc_d;
  logic          hit_q, run_q, over_q;
  logic          sc_clr, sc_inc;
  logic          btn_rise, tick, collide;
  logic [7:0]    step;

  assign btn_rise = button & ~btn_q;
  assign tick     = (cnt_q == TICK_LAST);
  assign collide  = (obst_q >= X_LO) && (obst_q <= X_HI) && (dinoY < Y_TOP);

`ifdef DINO_SPEEDUP_EN
  assign step = (score >= 16'h0050) ? 8'(2 * OBST_STEP) : STEP;
`else
  assign step = STEP;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    obst_d  = obst_q;
    jc_d    = jc_q;
    sc_clr  = 1'b0;
    sc_inc  = 1'b0;
    unique case (state_q)
      IDLE: if (btn_rise) state_d = RUN;
      RUN: begin
        // A collision freezes the whole datapath for that cycle.
        if (collide) begin
          state_d = HIT;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (obst_q >= step) begin
              obst_d = obst_q - step;
            end else begin
              obst_d = START;
              sc_inc = 1'b1;
            end
          end
          if (dinoJumpGood && (jc_q != 8'hFF)) jc_d = jc_q + 8'd1;
        end
      end
      HIT: state_d = OVER;
      OVER: begin
        if (btn_rise) begin
          state_d = RUN;
          obst_d  = START;
          jc_d    = '0;
          sc_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      cnt_q   <= '0;
      obst_q  <= START;
      jc_q    <= '0;
      hit_q   <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= button;
      cnt_q   <= cnt_d;
      obst_q  <= obst_d;
      jc_q    <= jc_d;
      hit_q   <= (state_d == HIT);
      run_q   <= (state_d == RUN);
      over_q  <= (state_d == OVER);
    end
  end

  dino_score_bcd #(.NUM_DIGITS(BCD_DIGITS)) u_score (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sc_clr),
    .inc_i  (sc_inc),
    .score_o(score)
  );

  assign obstX     = obst_q;
  assign jumpCount = jc_q;
  assign hit       = hit_q;
  assign running   = run_q;
  assign gameOver  = over_q;

endmodule

// File: tb/tb_dino_obstacle_game.sv
// Self-checking bench for dino_obstacle_game with TICK_DIV=4 and a game-level model.
module tb_dino_obstacle_game;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HIT = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst, button, dinoJumpGood;
  logic [7:0]  dinoY;
  logic [7:0]  obstX, jumpCount;
  logic [15:0] score;
  logic        hit, running, gameOver;

  int n_cmp = 0, n_bad = 0;

  // Game model: round phase, obstacle column, decimal score, jump tally.
  int m_state, m_obst, m_score, m_jc, m_runcyc;
  bit m_btn;

  always #5 clk = ~clk;

  dino_obstacle_game #(.TICK_DIV(TD)) u_dut (
    .clk(clk), .rst(rst), .button(button), .dinoY(dinoY),
    .dinoJumpGood(dinoJumpGood), .obstX(obstX), .score(score),
    .jumpCount(jumpCount), .hit(hit), .running(running), .gameOver(gameOver)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_obst = 159; m_score = 0; m_jc = 0; m_runcyc = 0; m_btn = 1'b0;
  endtask

  task automatic model_step(input bit b, input int y, input bit j);
    bit rise, tick, col;
    rise  = b && !m_btn;
    m_btn = b;
    case (m_state)
      M_IDLE: if (rise) begin m_state = M_RUN; m_runcyc = 0; end
      M_RUN: begin
        tick = (m_runcyc % TD) == TD - 1;
        m_runcyc++;
        col = (m_obst >= 20) && (m_obst <= 27) && (y < 113);
        if (col) m_state = M_HIT;
        else begin
          if (tick) begin
            if (m_obst >= 2) m_obst -= 2;
            else begin m_obst = 159; if (m_score < 9999) m_score++; end
          end
          if (j && m_jc < 255) m_jc++;
        end
      end
      M_HIT: m_state = M_OVER;
      default: if (rise) begin
        m_state = M_RUN; m_runcyc = 0; m_obst = 159; m_score = 0; m_jc = 0;
      end
    endcase
  endtask

  task automatic step(input logic b, input logic [7:0] y, input logic j);
    button = b; dinoY = y; dinoJumpGood = j;
    model_step(b, int'(y), j);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; dinoY = 8'd200; dinoJumpGood = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (obstX !== 8'd159) begin n_bad++; $display("FAIL rst_obstX: got %0d want 159", obstX); end
    n_cmp++; if (score !== 16'h0) begin n_bad++; $display("FAIL rst_score: got %h want 0000", score); end
    n_cmp++; if (jumpCount !== 8'd0) begin n_bad++; $display("FAIL rst_jc: got %0d want 0", jumpCount); end
    n_cmp++; if ({hit, running, gameOver} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {hit, running, gameOver}); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) step(1'b0, 8'd100, 1'b1);
    n_cmp++; if (running !== 1'b0 || obstX !== 8'd159 || jumpCount !== 8'd0) begin
      n_bad++; $display("FAIL idle_hold: got run=%b x=%0d jc=%0d want 0/159/0", running, obstX, jumpCount); end
  endtask

  task automatic test_start();
    step(1'b1, 8'd200, 1'b0);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b want 1", running); end
    n_cmp++; if (obstX !== 8'd159) begin n_bad++; $display("FAIL start_obst159: got %0d want 159", obstX); end
    repeat (4) step(1'b1, 8'd200, 1'b0);
    n_cmp++; if (obstX !== 8'd157) begin n_bad++; $display("FAIL start_obst157: got %0d want 157", obstX); end
    repeat (4) step(1'b1, 8'd200, 1'b0);
    n_cmp++; if (obstX !== 8'd155) begin n_bad++; $display("FAIL start_obst155: got %0d want 155", obstX); end
  endtask

  task automatic test_respawn();
    for (int i = 0; i < 400 && obstX !== 8'd1; i++) step(1'b0, 8'd200, 1'b0);
    n_cmp++; if (obstX !== 8'd1) begin n_bad++; $display("FAIL respawn_reach1: got %0d want 1", obstX); end
    repeat (4) step(1'b0, 8'd200, 1'b0);
    n_cmp++; if (obstX !== 8'd159) begin n_bad++; $display("FAIL respawn_obst: got %0d want 159", obstX); end
    n_cmp++; if (score !== 16'h0001) begin n_bad++; $display("FAIL respawn_score1: got %h want 0001", score); end
    for (int i = 0; i < 4000 && score !== 16'h0010; i++) begin
      step(1'b0, 8'd200, 1'b0);
      n_cmp++; if (obstX !== 8'(m_obst) || score !== to_bcd(m_score)) begin
        n_bad++; $display("FAIL respawn_track: got x=%0d s=%h want x=%0d s=%h", obstX, score, m_obst, to_bcd(m_score)); end
    end
    n_cmp++; if (score !== 16'h0010) begin n_bad++; $display("FAIL respawn_score10: got %h want 0010", score); end
  endtask

  task automatic test_collision();
    logic [15:0] sc;
    for (int i = 0; i < 400 && obstX !== 8'd27; i++) step(1'b0, 8'd200, 1'b0);
    sc = score;
    step(1'b0, 8'd101, 1'b0);
    n_cmp++; if (hit !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL coll_hit: got hit=%b run=%b want 1/0", hit, running); end
    n_cmp++; if (obstX !== 8'd27) begin n_bad++; $display("FAIL coll_obst: got %0d want 27", obstX); end
    step(1'b0, 8'd101, 1'b0);
    n_cmp++; if (hit !== 1'b0 || gameOver !== 1'b1) begin n_bad++; $display("FAIL coll_over: got hit=%b over=%b want 0/1", hit, gameOver); end
    repeat (8) step(1'b0, 8'd200, 1'b1);
    n_cmp++; if (obstX !== 8'd27 || score !== sc || gameOver !== 1'b1) begin
      n_bad++; $display("FAIL coll_freeze: got x=%0d s=%h over=%b want 27/%h/1", obstX, score, gameOver, sc); end
    n_cmp++; if (jumpCount !== 8'(m_jc)) begin n_bad++; $display("FAIL coll_jc_freeze: got %0d want %0d", jumpCount, m_jc); end
  endtask

  task automatic test_restart();
    step(1'b0, 8'd200, 1'b0);
    step(1'b1, 8'd200, 1'b0);
    n_cmp++; if (running !== 1'b1 || gameOver !== 1'b0) begin n_bad++; $display("FAIL restart_run: got run=%b over=%b want 1/0", running, gameOver); end
    n_cmp++; if (score !== 16'h0 || obstX !== 8'd159 || jumpCount !== 8'd0) begin
      n_bad++; $display("FAIL restart_vals: got s=%h x=%0d jc=%0d want 0000/159/0", score, obstX, jumpCount); end
  endtask

  task automatic test_jump();
    bit pulsed = 1'b0;
    logic [7:0] y;
    logic j;
    for (int i = 0; i < 800 && !(pulsed && obstX == 8'd17); i++) begin
      y = (m_obst >= 20 && m_obst <= 27) ? 8'd121 : (m_obst < 20 ? 8'd101 : 8'd200);
      j = (m_obst == 29) && !pulsed;
      if (j) pulsed = 1'b1;
      step(1'b0, y, j);
    end
    n_cmp++; if (obstX !== 8'd17) begin n_bad++; $display("FAIL jump_reach17: got %0d want 17", obstX); end
    n_cmp++; if (running !== 1'b1 || gameOver !== 1'b0) begin n_bad++; $display("FAIL jump_nohit: got run=%b over=%b want 1/0", running, gameOver); end
    n_cmp++; if (jumpCount !== 8'd1) begin n_bad++; $display("FAIL jump_count: got %0d want 1", jumpCount); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] o, jc;
    logic [15:0] s;
    for (int i = 0; i < 1000 && !(m_obst == 27 && (m_runcyc % TD) == TD - 1); i++)
      step(1'b0, 8'd200, 1'b0);
    o = obstX; s = score; jc = jumpCount;
    step(1'b0, 8'd101, 1'b1);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL simul_hit: got %b want 1", hit); end
    n_cmp++; if (obstX !== 8'd27 || obstX !== o) begin n_bad++; $display("FAIL simul_obst: got %0d want 27", obstX); end
    n_cmp++; if (score !== s || jumpCount !== jc) begin
      n_bad++; $display("FAIL simul_frozen: got s=%h jc=%0d want %h/%0d", score, jumpCount, s, jc); end
    step(1'b0, 8'd200, 1'b0);
    n_cmp++; if (gameOver !== 1'b1) begin n_bad++; $display("FAIL simul_over: got %b want 1", gameOver); end
  endtask

  task automatic test_jump_sat_and_reset();
    test_restart();
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 8'd200, 1'b1);
      n_cmp++; if (jumpCount !== 8'(m_jc)) begin n_bad++; $display("FAIL jsat_track: got %0d want %0d", jumpCount, m_jc); end
    end
    n_cmp++; if (jumpCount !== 8'd255) begin n_bad++; $display("FAIL jsat_255: got %0d want 255", jumpCount); end
    n_cmp++; if (score !== 16'h0001 || running !== 1'b1) begin n_bad++; $display("FAIL jsat_score: got s=%h run=%b want 0001/1", score, running); end
    #2; rst = 1'b1; model_reset();
    #1;
    n_cmp++; if (running !== 1'b0 || obstX !== 8'd159 || score !== 16'h0 || jumpCount !== 8'd0 || gameOver !== 1'b0 || hit !== 1'b0) begin
      n_bad++; $display("FAIL midrst: got run=%b x=%0d s=%h jc=%0d want 0/159/0000/0", running, obstX, score, jumpCount); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_random();
    logic b = 1'b0;
    logic [7:0] y;
    logic j;
    int r;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) b = ~b;
      r = int'($urandom_range(0, 9));
      y = (r == 0) ? 8'($urandom_range(0, 112)) : (r == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(113, 255));
      j = ($urandom_range(0, 3) == 0);
      step(b, y, j);
      n_cmp++; if (obstX !== 8'(m_obst)) begin n_bad++; $display("FAIL rnd_obstX cyc %0d: got %0d want %0d", i, obstX, m_obst); end
      n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL rnd_score cyc %0d: got %h want %h", i, score, to_bcd(m_score)); end
      n_cmp++; if (jumpCount !== 8'(m_jc)) begin n_bad++; $display("FAIL rnd_jc cyc %0d: got %0d want %0d", i, jumpCount, m_jc); end
      n_cmp++; if (hit !== (m_state == M_HIT)) begin n_bad++; $display("FAIL rnd_hit cyc %0d: got %b want %b", i, hit, m_state == M_HIT); end
      n_cmp++; if (running !== (m_state == M_RUN)) begin n_bad++; $display("FAIL rnd_running cyc %0d: got %b want %b", i, running, m_state == M_RUN); end
      n_cmp++; if (gameOver !== (m_state == M_OVER)) begin n_bad++; $display("FAIL rnd_over cyc %0d: got %b want %b", i, gameOver, m_state == M_OVER); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_respawn();
    test_collision();
    test_restart();
    test_jump();
    test_simultaneous();
    test_jump_sat_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
